parking_gate_ctrl: RTL and testbench
====================================

Name: parking_gate_ctrl

Overview:
Controller for a single-lane car park barrier that is shared between the entry ticket station and the exit pay station.
- Arbitrates entry and exit requests, opens the gate in one direction and waits for the lane sensor FSM's one-cycle pass pulse.
- Maintains occupancy against a capacity limit, closes the gate on timeout, and holds a close/settle interval before the next grant.
- Sits between the lane sensor FSM (entry/exit pulses) and the barrier actuator / status display.

Parameters:
CAP, 15, maximum occupancy (1..2**CNT_W-1)
CNT_W, 4, occupancy counter width
TIMEOUT, 16, cycles the gate stays open without a pass pulse before forced close (1..255)
CLOSE_CYC, 4, cycles held in CLOSE before returning to IDLE (1..255)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
entry_req  in  1  level, car waiting at entry station
exit_req  in  1  level, car waiting at exit station
entry_pulse  in  1  one-cycle pulse from sensor FSM: car passed inward
exit_pulse  in  1  one-cycle pulse from sensor FSM: car passed outward
gate_open  out  1  registered barrier-raise command
lane_dir  out  1  0 = entry direction, 1 = exit direction; valid while gate_open
count  out  CNT_W  current occupancy
full  out  1  count == CAP (combinational from count)
empty  out  1  count == 0 (combinational from count)
timeout  out  1  one-cycle pulse: open window expired without a pass
seq_err  out  1  one-cycle pulse: pass pulse not matching the open direction

Behaviour:
Reset (rst low, asynchronous):
- State = IDLE, gate_open = 0, lane_dir = 0, count = 0, timeout = 0, seq_err = 0, timer = 0, last_dir = 1.
- Because count = 0, full = 0 and empty = 1.
- Reset asserted mid-operation drops gate_open immediately. No count update occurs.

Eligibility (evaluated in IDLE only):
- ent_ok = entry_req & ~full.
- ext_ok = exit_req & ~empty.

States and transitions:
- IDLE:
  - ent_ok only -> OPEN_ENT.
  - ext_ok only -> OPEN_EXT.
  - Both eligible: round-robin. Grant the opposite of last_dir, so after reset entry wins.
  - Neither eligible -> stay in IDLE.
  - On grant: last_dir <= granted direction, timer <= 0.
- OPEN_ENT / OPEN_EXT:
  - gate_open = 1; lane_dir = 0 / 1.
  - timer increments every cycle.
  - Matching pulse (entry_pulse in OPEN_ENT, exit_pulse in OPEN_EXT): count ±1 on the same edge, -> CLOSE.
  - Else if timer == TIMEOUT-1: -> CLOSE, timeout pulses for 1 cycle, count unchanged.
  - Mismatched pulse: seq_err pulses, count unchanged, state unchanged, timer keeps running.
  - Matching and mismatched pulse in the same cycle: count updates and seq_err also pulses.
- CLOSE:
  - gate_open = 0.
  - timer counts from 0. At timer == CLOSE_CYC-1 -> IDLE.
  - Any pass pulse here or in IDLE: seq_err pulse, count unchanged.

Latency:
- Request sampled in IDLE at edge N; gate_open is high from N+1.
- Pass pulse sampled at edge M: count is new and gate_open is low from M+1.
- Minimum turnaround from pass pulse to the next gate_open is CLOSE_CYC+1 cycles.

Arithmetic and boundaries:
- count is never incremented past CAP and never decremented below 0. Eligibility guarantees this; as a defensive guard, count saturates anyway.
- full/empty are evaluated only in IDLE. An exit while full deasserts full the next cycle.
- A request dropped while its gate is open has no effect; the gate closes on pass or timeout.
- Requests held high during CLOSE are served on the IDLE cycle that follows.

Test Plan:
- Reset then entry_req=1, entry_pulse 3 cycles after gate_open -> gate_open=1, lane_dir=0 from the cycle after request; count 0->1; gate_open=0 next cycle; IDLE after 4 CLOSE cycles.
- entry_req and exit_req held high with count=5 -> grants alternate entry, exit, entry, exit; count returns to 5 after four completed passes.
- Fill to count=15 with entry_req and exit_req high -> full=1; only exit is granted; after exit_pulse count=14, full=0, and the next grant is entry.
- Grant entry and send no pulse -> gate_open stays high for exactly 16 cycles; timeout pulses once; count unchanged.
- exit_pulse during OPEN_ENT, and entry_pulse in IDLE -> seq_err pulses each time; count unchanged; state unchanged.
- rst low while OPEN_EXT with count=7 -> gate_open=0 and count=0 immediately; after release, exit_req alone is not granted because empty=1.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
// Single-lane barrier arbiter: grants entry/exit round-robin, tracks occupancy, forced close on timeout.
// Latency: gate_open one cycle after a sampled request; no backpressure, requests are levels held by the stations.
module parking_gate_ctrl #(
    parameter int CAP       = 15,
    parameter int CNT_W     = 4,
    parameter int TIMEOUT   = 16,
    parameter int CLOSE_CYC = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             entry_req_i,
    input  logic             exit_req_i,
    input  logic             entry_pulse_i,
    input  logic             exit_pulse_i,
    output logic             gate_open_o,
    output logic             lane_dir_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             timeout_o,
    output logic             seq_err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPEN_ENT,
        S_OPEN_EXT,
        S_CLOSE
    } state_t;

    localparam logic [CNT_W-1:0] CAP_V   = CNT_W'(CAP);
    localparam logic [7:0]       TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0]       CL_LAST = 8'(CLOSE_CYC - 1);

    state_t           state_q, state_d;
    logic [7:0]       timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             last_dir_q, last_dir_d;
    logic             lane_dir_q, lane_dir_d;
    logic             gate_open_q, gate_open_d;
    logic             timeout_q, timeout_d;
    logic             seq_err_q, seq_err_d;

    logic ent_ok;
    logic ext_ok;
    logic any_pulse;

    assign full_o  = (count_q == CAP_V);
    assign empty_o = (count_q == '0);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        count_d     = count_q;
        last_dir_d  = last_dir_q;
        lane_dir_d  = lane_dir_q;
        timeout_d   = 1'b0;
        seq_err_d   = 1'b0;
        ent_ok      = entry_req_i & ~full_o;
        ext_ok      = exit_req_i & ~empty_o;
        any_pulse   = entry_pulse_i | exit_pulse_i;

        case (state_q)
            S_IDLE: begin
                seq_err_d = any_pulse;
                // On a tie, last_dir_q == 1 means exit was served last, so entry goes next.
                if (ent_ok && (!ext_ok || last_dir_q)) begin
                    state_d    = S_OPEN_ENT;
                    last_dir_d = 1'b0;
                    lane_dir_d = 1'b0;
                    timer_d    = '0;
                end else if (ext_ok) begin
                    state_d    = S_OPEN_EXT;
                    last_dir_d = 1'b1;
                    lane_dir_d = 1'b1;
                    timer_d    = '0;
                end
            end
            S_OPEN_ENT: begin
                timer_d   = timer_q + 8'd1;
                seq_err_d = exit_pulse_i;
                if (entry_pulse_i) begin
                    if (count_q != CAP_V) count_d = count_q + 1'b1;
                    state_d = S_CLOSE;
                    timer_d = '0;
                end else if (timer_q == TO_LAST) begin
                    state_d   = S_CLOSE;
                    timer_d   = '0;
                    timeout_d = 1'b1;
                end
            end
            S_OPEN_EXT: begin
                timer_d   = timer_q + 8'd1;
                seq_err_d = entry_pulse_i;
                if (exit_pulse_i) begin
                    if (count_q != '0) count_d = count_q - 1'b1;
                    state_d = S_CLOSE;
                    timer_d = '0;
                end else if (timer_q == TO_LAST) begin
                    state_d   = S_CLOSE;
                    timer_d   = '0;
                    timeout_d = 1'b1;
                end
            end
            S_CLOSE: begin
                seq_err_d = any_pulse;
                timer_d   = timer_q + 8'd1;
                if (timer_q == CL_LAST) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        gate_open_d = (state_d == S_OPEN_ENT) || (state_d == S_OPEN_EXT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            count_q     <= '0;
            last_dir_q  <= 1'b1;
            lane_dir_q  <= 1'b0;
            gate_open_q <= 1'b0;
            timeout_q   <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            count_q     <= count_d;
            last_dir_q  <= last_dir_d;
            lane_dir_q  <= lane_dir_d;
            gate_open_q <= gate_open_d;
            timeout_q   <= timeout_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign gate_open_o = gate_open_q;
    assign lane_dir_o  = lane_dir_q;
    assign count_o     = count_q;
    assign timeout_o   = timeout_q;
    assign seq_err_o   = seq_err_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Randomized bench for parking_gate_ctrl: a window-countdown reference model predicts each cycle's outputs into a queue.
module tb_parking_gate_ctrl;

    localparam int CAP       = 15;
    localparam int CNT_W     = 4;
    localparam int TIMEOUT   = 16;
    localparam int CLOSE_CYC = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             entry_req = 1'b0;
    logic             exit_req = 1'b0;
    logic             entry_pulse = 1'b0;
    logic             exit_pulse = 1'b0;
    logic             gate_open;
    logic             lane_dir;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             timeout;
    logic             seq_err;

    parking_gate_ctrl #(
        .CAP(CAP), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .CLOSE_CYC(CLOSE_CYC)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .entry_req_i(entry_req), .exit_req_i(exit_req),
        .entry_pulse_i(entry_pulse), .exit_pulse_i(exit_pulse),
        .gate_open_o(gate_open), .lane_dir_o(lane_dir), .count_o(count),
        .full_o(full), .empty_o(empty), .timeout_o(timeout), .seq_err_o(seq_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             gate;
        logic             dir;
        logic [CNT_W-1:0] cnt;
        logic             full;
        logic             empty;
        logic             tout;
        logic             serr;
    } obs_t;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    event chk_ev;

    // Reference model: mode 0 idle, 1 gate up, 2 closing; m_left counts remaining cycles of the current window.
    int m_mode, m_dir, m_last, m_left, m_count, m_tout, m_serr;
    int p_er, p_xr, p_pass, p_bad, p_stray;

    function automatic void model_reset();
        m_mode = 0; m_dir = 0; m_last = 1; m_left = 0;
        m_count = 0; m_tout = 0; m_serr = 0;
    endfunction

    function automatic void model_step(input logic er, input logic xr, input logic ep, input logic xp);
        bit ent_ok, ext_ok, match, mism;
        m_tout = 0;
        m_serr = 0;
        if (m_mode == 0) begin
            if (ep || xp) m_serr = 1;
            ent_ok = er && (m_count < CAP);
            ext_ok = xr && (m_count > 0);
            if (ent_ok || ext_ok) begin
                if (ent_ok && ext_ok) m_dir = (m_last == 1) ? 0 : 1;
                else                  m_dir = ent_ok ? 0 : 1;
                m_last = m_dir;
                m_mode = 1;
                m_left = TIMEOUT;
            end
        end else if (m_mode == 1) begin
            match = (m_dir == 1) ? xp : ep;
            mism  = (m_dir == 1) ? ep : xp;
            if (mism) m_serr = 1;
            if (match) begin
                if (m_dir == 0 && m_count < CAP) m_count++;
                if (m_dir == 1 && m_count > 0)   m_count--;
                m_mode = 2;
                m_left = CLOSE_CYC;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 2;
                    m_left = CLOSE_CYC;
                    m_tout = 1;
                end
            end
        end else begin
            if (ep || xp) m_serr = 1;
            m_left--;
            if (m_left == 0) m_mode = 0;
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.gate  = (m_mode == 1);
        o.dir   = (m_dir == 1);
        o.cnt   = CNT_W'(m_count);
        o.full  = (m_count == CAP);
        o.empty = (m_count == 0);
        o.tout  = (m_tout != 0);
        o.serr  = (m_serr != 0);
        return o;
    endfunction

    // One clock of stimulus: drive on the falling edge, advance the model, queue the expectation.
    task automatic cycle(input logic rst_v);
        @(negedge clk);
        rst_n       = rst_v;
        entry_req   = ($urandom_range(99) < p_er);
        exit_req    = ($urandom_range(99) < p_xr);
        entry_pulse = 1'b0;
        exit_pulse  = 1'b0;
        if (m_mode == 1) begin
            if ($urandom_range(99) < p_pass) begin
                if (m_dir == 1) exit_pulse = 1'b1; else entry_pulse = 1'b1;
            end
            if ($urandom_range(99) < p_bad) begin
                if (m_dir == 1) entry_pulse = 1'b1; else exit_pulse = 1'b1;
            end
        end else if ($urandom_range(99) < p_stray) begin
            if ($urandom_range(1) == 0) entry_pulse = 1'b1; else exit_pulse = 1'b1;
        end
        if (!rst_v) model_reset();
        else        model_step(entry_req, exit_req, entry_pulse, exit_pulse);
        exp_q.push_back(model_obs());
    endtask

    task automatic set_knobs(input int er, input int xr, input int pass, input int bad, input int stray);
        p_er = er; p_xr = xr; p_pass = pass; p_bad = bad; p_stray = stray;
    endtask

    task automatic bound_fail(input string what);
        vectors++;
        miscompares++;
        $display("FAIL bound_%s: condition not reached within cycle budget", what);
    endtask

    // Monitor: compares after every rising edge, and immediately after an asynchronous reset.
    initial begin
        obs_t e, g;
        bit   ok;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g.gate = gate_open; g.dir = lane_dir; g.cnt = count; g.full = full;
                g.empty = empty; g.tout = timeout; g.serr = seq_err;
                ok = (g.gate === e.gate) && (!e.gate || (g.dir === e.dir)) &&
                     (g.cnt === e.cnt) && (g.full === e.full) && (g.empty === e.empty) &&
                     (g.tout === e.tout) && (g.serr === e.serr);
                vectors++;
                if (!ok) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t got gate=%b dir=%b cnt=%0d full=%b empty=%b tout=%b serr=%b, want gate=%b dir=%b cnt=%0d full=%b empty=%b tout=%b serr=%b",
                             $time, g.gate, g.dir, g.cnt, g.full, g.empty, g.tout, g.serr,
                             e.gate, e.dir, e.cnt, e.full, e.empty, e.tout, e.serr);
                end
            end
        end
    end

    initial begin
        model_reset();
        set_knobs(0, 0, 0, 0, 0);
        repeat (3) cycle(1'b0);

        // Fill toward capacity, then keep entry requesting while full.
        set_knobs(100, 0, 40, 0, 0);
        repeat (400) cycle(1'b1);
        if (m_count != CAP) bound_fail("fill");

        // Both stations waiting: grants should alternate, exit first while full.
        set_knobs(100, 100, 50, 0, 0);
        repeat (300) cycle(1'b1);

        // No pass pulses: every grant ends in a forced close.
        set_knobs(50, 50, 0, 0, 0);
        repeat (150) cycle(1'b1);

        // Wrong-direction and stray pulses.
        set_knobs(50, 50, 30, 20, 20);
        repeat (600) cycle(1'b1);

        set_knobs(40, 60, 20, 5, 5);
        repeat (600) cycle(1'b1);

        // Steer occupancy to 7, then reset asynchronously while the exit gate is open.
        begin
            int i;
            for (i = 0; i < 2000 && !(m_count == 7 && m_mode == 0); i++) begin
                set_knobs((m_count < 7) ? 100 : 0, (m_count > 7) ? 100 : 0, 60, 0, 0);
                cycle(1'b1);
            end
            if (!(m_count == 7 && m_mode == 0)) bound_fail("count7");
            set_knobs(0, 100, 0, 0, 0);
            for (i = 0; i < 200 && !(m_mode == 1 && m_dir == 1); i++) cycle(1'b1);
            if (!(m_mode == 1 && m_dir == 1)) bound_fail("open_exit");
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        exp_q.push_back(model_obs());
        ->chk_ev;
        set_knobs(0, 100, 0, 0, 0);
        repeat (2) cycle(1'b0);
        repeat (20) cycle(1'b1);

        set_knobs(60, 40, 30, 10, 10);
        repeat (500) cycle(1'b1);

        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
